odd_div_clkgen: RTL and testbench
=================================

Name: odd_div_clkgen

Overview:
- Output stage of the odd-number frequency divider; sits directly downstream of the mod-N counter.
- Consumes the counter's registered count and produces a 50%-duty divided clock, clk/N, for odd N.
- Uses a posedge waveform flop plus a negedge retimed copy, ORed together.
- Adds glitch-free start/stop gating on whole output periods, plus a lock indication.

Parameters:
- N, 3, division ratio; must be odd and >= 3, matching the counter's N.
- CW, $clog2(N), count input width.

Ports:
- clk  input  1  source clock; the same clock that drives the counter.
- rst  input  1  asynchronous, active-low reset. Asserting it low clears all state immediately; release is synchronous to clk.
- cnt  input  CW  counter value, registered on posedge clk. Sequence is 0..N-1, wrapping to 0.
- en  input  1  request divided output; level-sensitive, sampled on posedge clk.
- clk_out  output  1  divided clock, period N·Tclk, high time N/2·Tclk.
- active  output  1  high while the gate is open (RUN or DRAIN).
- locked  output  1  high once one complete gated period has been emitted.
- err  output  1  sticky count-sequence error; see Optional Feature.

Behaviour:
- Definitions:
  - HALF = (N-1)/2.
  - A boundary edge is a posedge clk at which the sampled cnt == N-1.
- Reset (rst=0): state=IDLE, pos_q=0, neg_q=0, locked=0, err=0, active=0. Therefore clk_out=0.
- State machine, updated on posedge clk:
  - IDLE: en=1 and boundary edge -> RUN. Otherwise stay in IDLE.
  - RUN: en=0 and not boundary edge -> DRAIN. en=0 and boundary edge -> IDLE. Otherwise stay in RUN.
  - DRAIN: boundary edge -> IDLE (if en=1 at that edge -> RUN). Otherwise stay in DRAIN.
- active = (state != IDLE), registered.
- Waveform generation:
  - pos_q <= active_q && (cnt < HALF), on posedge, where active_q is the pre-edge value.
  - neg_q <= pos_q, on negedge clk.
  - clk_out = pos_q | neg_q.
  - Result: high for HALF+0.5 = N/2 clock periods, low for N/2.
- Gating takes effect only at boundaries, so no runt pulses occur:
  - The first high phase starts one edge after the RUN entry edge.
  - The last low phase completes before IDLE.
- Start latency: from en=1 sampled, at most N edges to the boundary, then +1 edge to clk_out rising.
- locked:
  - Set at the first boundary edge reached while in RUN or DRAIN, i.e. one full period has been emitted.
  - Cleared on entering IDLE.
- en toggling mid-period has no effect until the boundary edge; only the value at the boundary edge matters for IDLE/DRAIN exit.
- If rst is asserted mid-period, clk_out goes low asynchronously: pos_q and neg_q are both cleared.
- Out-of-range cnt (> N-1) is treated as not a boundary and yields pos_q=0.

Optional Feature:
- Macro: ODD_DIV_SEQ_CHECK_EN.
- Defined:
  - Keep prev_cnt, reset value N-1.
  - At each posedge, err sets if cnt > N-1, or if cnt != (prev_cnt==N-1 ? 0 : prev_cnt+1).
  - err is sticky until rst.
  - The first edge after reset expects cnt==0.
- Not defined: err tied to 0 and prev_cnt is absent.

Decomposition:
- Package odd_div_pkg holds:
  - the state enum {IDLE, RUN, DRAIN}, 2 bits;
  - function half_of(N) returning (N-1)/2;
  - function next_cnt(c, N) for the sequence check.
- One sub-module, neg_retime: a single negedge flop with async active-low clear (d=pos_q, q=neg_q). It isolates the negedge clocking for timing constraints and lint waivers.

Test Plan:
- N=3, counter free-running, en=1 from reset release -> RUN at the first boundary; clk_out period 3 clks, high 1.5 clks; locked high after the first emitted period.
- N=5, en=1 then en=0 mid high phase at cnt=1 -> DRAIN; the current period completes (high 2.5, low 2.5), then IDLE; clk_out stays 0; no pulse shorter than 2.5 clks.
- N=7, en pulsed high for 2 clks not covering cnt==6 -> state stays IDLE, clk_out=0, active=0.
- N=5 running, rst driven low asynchronously mid-period -> clk_out, active and locked go 0 without waiting for clk; after release and with en=1, restart only at the next cnt==4 boundary.
- N=5 running, en=0 exactly at a boundary edge -> RUN->IDLE directly; no additional period emitted.
- ODD_DIV_SEQ_CHECK_EN defined, N=5: inject cnt sequence 0,1,3 -> err=1 at the edge sampling 3 and remains 1. Inject cnt=6 in a fresh run -> err=1. Macro undefined -> err=0 throughout.

Source files
------------

// File: rtl/odd_div_pkg.sv
// ----------------------------------------------------------------------------
// odd_div_pkg : state type and count helpers for the odd-N clock divider.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package odd_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int half_of(input int n);
        return (n - 1) / 2;
    endfunction

    function automatic int next_cnt(input int c, input int n);
        return (c == n - 1) ? 0 : c + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/neg_retime.sv
// ----------------------------------------------------------------------------
// neg_retime : single falling-edge flop with async active-low clear.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module neg_retime (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/odd_div_clkgen.sv
// ----------------------------------------------------------------------------
// odd_div_clkgen : 50% duty clk/N output stage with period-aligned gating.
// Optional count-sequence checker: ODD_DIV_SEQ_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module odd_div_clkgen
    import odd_div_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt,
    input  logic          en,
    output logic          clk_out,
    output logic          active,
    output logic          locked,
    output logic          err
);

    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_HALF = CW'(half_of(N));

    state_e state_q, state_d;
    logic   active_q;
    logic   pos_q;
    logic   neg_q;
    logic   locked_q, locked_d;
    logic   w_boundary;

    assign w_boundary = (cnt == C_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && w_boundary) state_d = RUN;
            RUN:     if (!en) state_d = w_boundary ? IDLE : DRAIN;
            DRAIN:   if (w_boundary) state_d = en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entering IDLE wins over the boundary that would otherwise set locked.
    always_comb begin
        locked_d = locked_q;
        if (state_d == IDLE) begin
            locked_d = 1'b0;
        end else if (w_boundary && (state_q != IDLE)) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            pos_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d != IDLE);
            pos_q    <= active_q && (cnt < C_HALF);
            locked_q <= locked_d;
        end
    end

    neg_retime u_neg_retime (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (pos_q),
        .q_o    (neg_q)
    );

    // The falling-edge copy stretches the high phase by half a source period.
    assign clk_out = pos_q | neg_q;
    assign active  = active_q;
    assign locked  = locked_q;

`ifdef ODD_DIV_SEQ_CHECK_EN
    logic [CW-1:0] prev_cnt_q;
    logic          err_q;
    logic          w_seq_bad;

    assign w_seq_bad = (cnt > C_LAST) ||
                       (cnt != CW'(next_cnt(int'(prev_cnt_q), N)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt_q <= C_LAST;
            err_q      <= 1'b0;
        end else begin
            prev_cnt_q <= cnt;
            err_q      <= err_q | w_seq_bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_odd_div_clkgen.sv
// ----------------------------------------------------------------------------
// tb_odd_div_clkgen : directed scoreboard bench for N = 3, 5 and 7 instances.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_odd_div_clkgen;

`ifdef ODD_DIV_SEQ_CHECK_EN
    localparam logic SEQ = 1'b1;
`else
    localparam logic SEQ = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] cnt3;
    logic [2:0] cnt5;
    logic [2:0] cnt7;
    logic       en3, en5, en7;
    logic       out3, out5, out7;
    logic       active3, active5, active7;
    logic       locked3, locked5, locked7;
    logic       err3, err5, err7;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   tick_no = 0;
    logic inj = 1'b0;
    logic sp3, sn3, sp5, sn5, sp7, sn7;
    logic exp_q[$];

    odd_div_clkgen #(.N(3)) u_dut3 (
        .clk(clk), .rst(rst), .cnt(cnt3), .en(en3),
        .clk_out(out3), .active(active3), .locked(locked3), .err(err3)
    );
    odd_div_clkgen #(.N(5)) u_dut5 (
        .clk(clk), .rst(rst), .cnt(cnt5), .en(en5),
        .clk_out(out5), .active(active5), .locked(locked5), .err(err5)
    );
    odd_div_clkgen #(.N(7)) u_dut7 (
        .clk(clk), .rst(rst), .cnt(cnt7), .en(en7),
        .clk_out(out7), .active(active7), .locked(locked7), .err(err7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // One output period: N high half-cycles followed by N low half-cycles.
    task automatic push_period(input int n);
        push_bits(1'b1, n);
        push_bits(1'b0, n);
    endtask

    // One source cycle: the counters behave as registers updated at posedge.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        cnt3 = (cnt3 == 2'd2) ? 2'd0 : cnt3 + 2'd1;
        if (!inj) cnt5 = (cnt5 == 3'd4) ? 3'd0 : cnt5 + 3'd1;
        cnt7 = (cnt7 == 3'd6) ? 3'd0 : cnt7 + 3'd1;
        sp3 = out3; sp5 = out5; sp7 = out7;
        @(negedge clk);
        #1;
        sn3 = out3; sn5 = out5; sn7 = out7;
    endtask

    task automatic run_n(input int sel, input int n);
        logic e0, e1, op, on;
        for (int i = 0; i < n; i++) begin
            tick();
            case (sel)
                3:       begin op = sp3; on = sn3; end
                5:       begin op = sp5; on = sn5; end
                default: begin op = sp7; on = sn7; end
            endcase
            if (exp_q.size() < 2) begin
                n_cmp++;
                n_mis++;
                $error("FAIL scoreboard_empty_n%0d: observed tick %0d expected queued value", sel, tick_no);
            end else begin
                e0 = exp_q.pop_front();
                e1 = exp_q.pop_front();
                chk($sformatf("clk_out_n%0d_t%0d_hi_clk", sel, tick_no), op, e0);
                chk($sformatf("clk_out_n%0d_t%0d_lo_clk", sel, tick_no), on, e1);
            end
        end
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        cnt3 = 2'd0; cnt5 = 3'd0; cnt7 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out5", out5, 1'b0);
        chk("rst_active5", active5, 1'b0);
        chk("rst_locked5", locked5, 1'b0);
        chk("rst_err5", err5, 1'b0);
        chk("rst_clk_out3", out3, 1'b0);
        chk("rst_clk_out7", out7, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        en3 = 1'b0; en5 = 1'b0; en7 = 1'b0;
        cnt3 = 2'd0; cnt5 = 3'd0; cnt7 = 3'd0;

        // N=3 free-running with en high from reset release.
        en3 = 1'b1;
        do_reset();
        push_bits(1'b0, 6);
        run_n(3, 3);
        chk("n3_active_after_entry", active3, 1'b1);
        chk("n3_locked_before_period", locked3, 1'b0);
        push_period(3);
        run_n(3, 3);
        chk("n3_locked_after_period", locked3, 1'b1);
        push_period(3);
        push_period(3);
        run_n(3, 6);
        chk("n3_err", err3, 1'b0);

        // N=5: drop en in the high phase, the period drains out then IDLE.
        en3 = 1'b0;
        en5 = 1'b1;
        do_reset();
        push_bits(1'b0, 10);
        run_n(5, 5);
        chk("n5_active_run", active5, 1'b1);
        push_period(5);
        run_n(5, 5);
        chk("n5_locked", locked5, 1'b1);
        push_period(5);
        run_n(5, 1);
        en5 = 1'b0;
        run_n(5, 1);
        chk("n5_drain_active", active5, 1'b1);
        run_n(5, 3);
        chk("n5_drain_idle_active", active5, 1'b0);
        chk("n5_drain_idle_locked", locked5, 1'b0);

        // N=5: re-enable, then drop en exactly at a boundary edge.
        en5 = 1'b1;
        push_bits(1'b0, 10);
        run_n(5, 5);
        chk("n5_rerun_active", active5, 1'b1);
        push_period(5);
        run_n(5, 4);
        en5 = 1'b0;
        run_n(5, 1);
        chk("n5_bnd_stop_active", active5, 1'b0);
        chk("n5_bnd_stop_locked", locked5, 1'b0);
        push_bits(1'b0, 10);
        run_n(5, 5);

        // N=5: asynchronous reset in the middle of a high phase.
        en5 = 1'b1;
        push_bits(1'b0, 10);
        run_n(5, 5);
        push_period(5);
        run_n(5, 5);
        chk("n5_locked_pre_rst", locked5, 1'b1);
        push_bits(1'b1, 2);
        run_n(5, 1);
        #1;
        rst  = 1'b0;
        cnt3 = 2'd0; cnt5 = 3'd0; cnt7 = 3'd0;
        #1;
        chk("n5_async_clk_out", out5, 1'b0);
        chk("n5_async_active", active5, 1'b0);
        chk("n5_async_locked", locked5, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        push_bits(1'b0, 8);
        run_n(5, 4);
        chk("n5_restart_wait_active", active5, 1'b0);
        push_bits(1'b0, 2);
        run_n(5, 1);
        chk("n5_restart_active", active5, 1'b1);
        push_period(5);
        run_n(5, 5);
        chk("n5_err_clean", err5, 1'b0);

        // N=7: en pulse that misses the boundary leaves the gate closed.
        en5 = 1'b0;
        do_reset();
        push_bits(1'b0, 28);
        run_n(7, 1);
        en7 = 1'b1;
        run_n(7, 2);
        en7 = 1'b0;
        run_n(7, 11);
        chk("n7_active", active7, 1'b0);
        chk("n7_locked", locked7, 1'b0);
        chk("n7_err", err7, 1'b0);

        // N=5: injected count sequences for the sequence checker.
        inj = 1'b1;
        do_reset();
        tick();
        chk("seq_first_zero", err5, 1'b0);
        cnt5 = 3'd1;
        tick();
        chk("seq_one", err5, 1'b0);
        cnt5 = 3'd3;
        tick();
        chk("seq_skip", err5, SEQ);
        cnt5 = 3'd4;
        tick();
        cnt5 = 3'd0;
        tick();
        chk("seq_sticky", err5, SEQ);
        chk("seq_n3_clean", err3, 1'b0);
        do_reset();
        tick();
        cnt5 = 3'd6;
        tick();
        chk("seq_out_of_range", err5, SEQ);
        chk("seq_oor_clk_out", out5, 1'b0);
        inj = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
